out_t_fifo: RTL and testbench

//   Downstream buffering stage for the typed output 'o' (type OUT_t) of InstModule.

---
 rtl/out_t_fifo_pkg.sv | 15 +
 rtl/out_t_fifo_if.sv | 32 +++
 rtl/out_t_fifo_ptr.sv | 39 +++
 rtl/out_t_fifo.sv | 103 ++++++++++
 tb/tb_out_t_fifo.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/out_t_fifo_pkg.sv
// Shared helpers for the out_t_fifo buffering stage: count width and the
// elaboration-time depth check. The record type stays a module parameter.
package out_t_fifo_pkg;

  localparam int MIN_DEPTH = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return depth >= MIN_DEPTH;
  endfunction

endpackage

// File: rtl/out_t_fifo_if.sv
// Producer/consumer handshake bundle for out_t_fifo, plus occupancy and
// overflow status. The master side drives records in and takes them out.
interface out_t_fifo_if
  import out_t_fifo_pkg::*;
#(
  parameter type OUT_t = logic [7:0],
  parameter int  DEPTH = 4
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic             in_valid;
  OUT_t             in_data;
  logic             in_ready;
  logic             out_valid;
  OUT_t             out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             err_ovf;
  logic             clr_err;

  modport master (
    output in_valid, in_data, out_ready, clr_err,
    input  in_ready, out_valid, out_data, count, err_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready, clr_err,
    output in_ready, out_valid, out_data, count, err_ovf
  );

endinterface

// File: rtl/out_t_fifo_ptr.sv
// One FIFO pointer counting modulo DEPTH; advances by one when inc is high.
module out_t_fifo_ptr
  import out_t_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Explicit wrap keeps non-power-of-2 depths from visiting unused slots.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/out_t_fifo.sv
// First-word fall-through FIFO for OUT_t records with a sticky overflow flag.
// Full blocks pushes even when the consumer pops in the same cycle.
module out_t_fifo
  import out_t_fifo_pkg::*;
#(
  parameter type OUT_t = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  out_t_fifo_if.slave bus
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("out_t_fifo: DEPTH must be at least 2");
  end

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             err_q;
  logic             err_d;
  OUT_t             mem_q [DEPTH];
  OUT_t             mem_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;

  // Ready ignores out_ready on purpose: no pass-through when full.
  assign in_ready  = !rst && (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  out_t_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  out_t_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Set has priority over clear when both land in the same cycle.
  always_comb begin
    err_d = err_q;
    if (bus.clr_err) begin
      err_d = 1'b0;
    end
    if (bus.in_valid && !in_ready && !rst) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr] = bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage carries no reset; stale entries are hidden by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = mem_q[rd_ptr];
  assign bus.count     = count_q;
  assign bus.err_ovf   = err_q;

endmodule

// File: tb/tb_out_t_fifo.sv
// Bench for out_t_fifo: directed cases on a depth-4 instance, random traffic on
// a depth-3 instance, both compared against queue-based reference models.
module tb_out_t_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  out_t_fifo_if #(.OUT_t(logic [7:0]), .DEPTH(4)) if4 ();
  out_t_fifo_if #(.OUT_t(logic [7:0]), .DEPTH(3)) if3 ();

  out_t_fifo #(.OUT_t(logic [7:0]), .DEPTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  out_t_fifo #(.OUT_t(logic [7:0]), .DEPTH(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  m4 [$];
  logic [7:0]  m3 [$];
  bit          e4, e3;
  int unsigned wr4, rd4, wr3, rd3;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m4.delete(); m3.delete();
    e4 = 0; e3 = 0;
    wr4 = 0; rd4 = 0; wr3 = 0; rd3 = 0;
  endtask

  // Apply one clock edge worth of FIFO rules to both models.
  task automatic model_edge();
    bit p, q, ov;
    if (rst) return;
    p  = if4.in_valid && m4.size() < 4;
    q  = if4.out_ready && m4.size() > 0;
    ov = if4.in_valid && m4.size() == 4;
    if (q) begin void'(m4.pop_front()); rd4++; end
    if (p) begin m4.push_back(if4.in_data); wr4++; end
    if (ov) e4 = 1; else if (if4.clr_err) e4 = 0;
    p  = if3.in_valid && m3.size() < 3;
    q  = if3.out_ready && m3.size() > 0;
    ov = if3.in_valid && m3.size() == 3;
    if (q) begin void'(m3.pop_front()); rd3++; end
    if (p) begin m3.push_back(if3.in_data); wr3++; end
    if (ov) e3 = 1; else if (if3.clr_err) e3 = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check4();
    chk("cnt4", if4.count, m4.size());
    chk("ovld4", if4.out_valid, m4.size() != 0);
    chk("irdy4", if4.in_ready, !rst && m4.size() < 4);
    chk("err4", if4.err_ovf, e4);
    if (m4.size() != 0) chk("data4", if4.out_data, m4[0]);
    chk("wptr4", dut4.wr_ptr, wr4 % 4);
    chk("rptr4", dut4.rd_ptr, rd4 % 4);
  endtask

  task automatic check3();
    chk("cnt3", if3.count, m3.size());
    chk("ovld3", if3.out_valid, m3.size() != 0);
    chk("irdy3", if3.in_ready, !rst && m3.size() < 3);
    chk("err3", if3.err_ovf, e3);
    if (m3.size() != 0) chk("data3", if3.out_data, m3[0]);
    chk("wptr3", dut3.wr_ptr, wr3 % 3);
    chk("rptr3", dut3.rd_ptr, rd3 % 3);
    chk("cnt3_max", if3.count <= 3, 1);
  endtask

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    if4.in_valid = 0; if4.in_data = '0; if4.out_ready = 0; if4.clr_err = 0;
    if3.in_valid = 0; if3.in_data = '0; if3.out_ready = 0; if3.clr_err = 0;
    model_reset();

    // Power-on reset, then synchronous release.
    #1;
    chk("rst_cnt", if4.count, 0);
    chk("rst_ovld", if4.out_valid, 0);
    chk("rst_err", if4.err_ovf, 0);
    chk("rst_irdy", if4.in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("rel_irdy", if4.in_ready, 1);
    check4();

    // Fill with the consumer stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      if4.in_valid = 1; if4.in_data = fill[i];
      tick();
      check4();
    end
    if4.in_valid = 0;
    chk("full_cnt", if4.count, 4);
    chk("full_irdy", if4.in_ready, 0);
    if4.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", if4.out_data, fill[i]);
      chk("drain_vld", if4.out_valid, 1);
      tick();
    end
    chk("drain_empty", if4.out_valid, 0);
    if4.out_ready = 0;

    // One-cycle latency, no bypass.
    if4.in_valid = 1; if4.in_data = 8'hA5;
    #1;
    chk("lat_before", if4.out_valid, 0);
    tick();
    if4.in_valid = 0;
    chk("lat_after_vld", if4.out_valid, 1);
    chk("lat_after_data", if4.out_data, 8'hA5);
    if4.out_ready = 1;
    tick();
    check4();
    if4.out_ready = 0;

    // Reach count 2, then stream through with simultaneous push/pop.
    for (int i = 0; i < 2; i++) begin
      if4.in_valid = 1; if4.in_data = 8'(8'h60 + i);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      if4.in_valid = 1; if4.out_ready = 1; if4.in_data = 8'($urandom);
      tick();
      chk("pp_cnt", if4.count, 2);
      check4();
    end
    if4.in_valid = 0; if4.out_ready = 0;

    // Full with a pop: the push is refused and flagged.
    for (int i = 0; i < 2; i++) begin
      if4.in_valid = 1; if4.in_data = 8'(8'h70 + i);
      tick();
    end
    chk("ovf_pre_cnt", if4.count, 4);
    if4.in_valid = 1; if4.in_data = 8'h55; if4.out_ready = 1;
    #1;
    chk("ovf_irdy", if4.in_ready, 0);
    tick();
    if4.in_valid = 0; if4.out_ready = 0;
    chk("ovf_cnt", if4.count, 3);
    chk("ovf_err", if4.err_ovf, 1);
    check4();
    if4.clr_err = 1;
    tick();
    if4.clr_err = 0;
    chk("clr_err", if4.err_ovf, 0);
    check4();

    // Set and clear together: set wins.
    if4.in_valid = 1; if4.in_data = 8'h77;
    tick();
    if4.in_data = 8'h78; if4.clr_err = 1;
    tick();
    if4.in_valid = 0; if4.clr_err = 0;
    chk("set_wins", if4.err_ovf, 1);
    check4();
    if4.out_ready = 1;
    tick();
    if4.out_ready = 0;
    chk("pre_rst_cnt", if4.count, 3);

    // Asynchronous reset mid-stream with three records held.
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("mid_rst_cnt", if4.count, 0);
    chk("mid_rst_ovld", if4.out_valid, 0);
    chk("mid_rst_err", if4.err_ovf, 0);
    chk("mid_rst_irdy", if4.in_ready, 0);
    tick();
    chk("mid_rst_irdy2", if4.in_ready, 0);
    rst = 0;
    #1;
    chk("mid_rel_irdy", if4.in_ready, 1);
    check4();

    // Random traffic on the depth-3 instance.
    for (int i = 0; i < 1000; i++) begin
      if3.in_valid  = ($urandom_range(0, 9) < 6);
      if3.in_data   = 8'($urandom);
      if3.out_ready = ($urandom_range(0, 1) == 1);
      if3.clr_err   = ($urandom_range(0, 19) == 0);
      tick();
      check3();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
